packet_rd_align: RTL and testbench
==================================

PACKET_RD_ALIGN -- requirements
Module: packet_rd_align

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 rd_en  input  1  single-cycle read request from controller; sampled only in IDLE.
REQ-004 addr  input  12  byte address into packet memory (absolute or indirect, already resolved).
REQ-005 transfer_sz  input  2  00 word (4 B), 01 half-word (2 B), 10 byte, 11 invalid.
REQ-006 packet_len  input  13  valid packet length in bytes, 0..4096.
REQ-007 mem_rd_en  output  1  read strobe to 32-bit packet BRAM; data returns one cycle later.
REQ-008 mem_addr  output  10  word address to packet BRAM.
REQ-009 mem_rdata  input  32  BRAM read data; byte at lowest address in bits [31:24] (network order).
REQ-010 rd_data  output  32  zero-extended result; held until next result or error.
REQ-011 data_valid  output  1  one-cycle pulse: rd_data is new.
REQ-012 oob_err  output  1  one-cycle pulse: request rejected, rd_data forced to 0.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, FIRST, SECOND; encoding free.
REQ-015 nbytes SHALL be 4/2/1 for sz 00/01/10; request SHALL be rejected if sz=11 or addr+nbytes > packet_len, compared at 13 bits (no overflow).
REQ-016 IDLE with rd_en and accepted: mem_rd_en=1, mem_addr=addr[11:2] combinationally that cycle; addr[1:0], sz latched; next state FIRST.
REQ-017 IDLE with rd_en and rejected: no mem_rd_en; next cycle oob_err=1, rd_data=0; state stays IDLE.
REQ-018 Span SHALL be defined as addr[1:0]+nbytes > 4.
REQ-019 FIRST, no span: result formed from mem_rdata, registered; data_valid=1 next cycle; next state IDLE.
REQ-020 FIRST, span: mem_rdata latched as word0; mem_rd_en=1, mem_addr=latched word address+1; next state SECOND.
REQ-021 SECOND: result formed from {word0, mem_rdata}; data_valid=1 next cycle; next state IDLE.
REQ-022 Latency rd_en-cycle to data_valid-cycle: 2 cycles non-spanning, 3 spanning; oob_err 1 cycle.
REQ-023 Extraction: 64-bit {word0,word1} (word1=0 when no span), byte i at bits [63-8i:56-8i]; result = bytes o..o+nbytes-1 with o=addr[1:0], first byte most significant, zero-extended to 32.
REQ-024 rd_en while busy SHALL be ignored (no queueing); rd_en in data_valid cycle SHALL be accepted (IDLE).
REQ-025 Word address +1 never wraps: REQ-015 guarantees addr+nbytes ≤ 4096.
REQ-026 data_valid and oob_err SHALL never be high in the same cycle.

Reset
REQ-027 rst low SHALL immediately force IDLE, rd_data=0, data_valid=0, oob_err=0, busy=0, mem_rd_en=0, latched fields 0.
REQ-028 Reset mid-operation SHALL discard the pending request; no data_valid follows, and BRAM data returning after release SHALL be ignored.

Structure
REQ-029 Shared package bpf_pkg SHALL hold transfer-size encodings (W/H/B), packet address width 12, word address width 10, state type.
REQ-030 Combinational sub-module pkt_byte_align SHALL implement REQ-023 (inputs 64-bit pair, offset, size; output 32-bit); FSM stays in packet_rd_align.

Verification (BRAM model: word0=0x11223344, word1=0x55667788; packet_len=64 unless noted)
REQ-031 addr=0, sz=W -> one mem read at word 0; rd_data=0x11223344, data_valid 2 cycles after rd_en.
REQ-032 addr=3, sz=W -> reads word 0 then 1 in consecutive cycles; rd_data=0x44556677, data_valid 3 cycles after rd_en.
REQ-033 addr=5, sz=H -> 0x00006677 (2 cycles); addr=3, sz=H -> 0x00004455 (3 cycles); addr=7, sz=B -> 0x00000088.
REQ-034 packet_len=6, addr=4, sz=W -> no mem_rd_en, oob_err pulse next cycle, rd_data=0; sz=11 at addr=0 -> same.
REQ-035 Second rd_en during FIRST of spanning read -> ignored, exactly one data_valid; rst low during SECOND -> outputs zero at once, no data_valid after release.
REQ-036 Back-to-back: rd_en addr=0 W, then rd_en addr=4 W in the data_valid cycle -> 0x11223344 then 0x55667788, two cycles apart.

Source files
------------

// File: rtl/bpf_pkg.sv
// Shared encodings and types for the packet read/align datapath.
// Holds transfer-size codes, address widths and the read FSM state type.
package bpf_pkg;

  localparam int PKT_AW  = 12;
  localparam int WORD_AW = 10;

  typedef enum logic [1:0] {
    SZ_W   = 2'b00,
    SZ_H   = 2'b01,
    SZ_B   = 2'b10,
    SZ_INV = 2'b11
  } xfer_sz_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FIRST  = 2'b01,
    ST_SECOND = 2'b10
  } state_e;

  // Byte count for a transfer size; 0 marks the invalid encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_W:    n = 3'd4;
      SZ_H:    n = 3'd2;
      SZ_B:    n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/packet_rd_align_if.sv
// Controller-side read request/response and packet BRAM port bundle.
// The slave modport is the aligner; the master modport is its environment.
interface packet_rd_align_if;

  logic                         rd_en;
  logic [bpf_pkg::PKT_AW-1:0]   addr;
  logic [1:0]                   transfer_sz;
  logic [12:0]                  packet_len;
  logic                         mem_rd_en;
  logic [bpf_pkg::WORD_AW-1:0]  mem_addr;
  logic [31:0]                  mem_rdata;
  logic [31:0]                  rd_data;
  logic                         data_valid;
  logic                         oob_err;
  logic                         busy;

  modport slave (
    input  rd_en, addr, transfer_sz, packet_len, mem_rdata,
    output mem_rd_en, mem_addr, rd_data, data_valid, oob_err, busy
  );

  modport master (
    output rd_en, addr, transfer_sz, packet_len, mem_rdata,
    input  mem_rd_en, mem_addr, rd_data, data_valid, oob_err, busy
  );

endinterface

// File: rtl/pkt_byte_align.sv
// Picks nbytes starting at byte offset off out of a big-endian 64-bit word pair,
// first byte most significant, zero-extended to 32 bits.
module pkt_byte_align
  import bpf_pkg::*;
(
  input  logic [63:0] pair,
  input  logic [1:0]  off,
  input  logic [1:0]  sz,
  output logic [31:0] data
);

  logic [63:0] shifted_s;
  logic [31:0] top_s;

  // Left-justify the selected bytes, then trim to the transfer size.
  always_comb begin
    shifted_s = pair << {off, 3'b000};
    top_s     = shifted_s[63:32];
    case (sz)
      SZ_W:    data = top_s;
      SZ_H:    data = {16'h0000, top_s[31:16]};
      SZ_B:    data = {24'h000000, top_s[31:24]};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/packet_rd_align.sv
// Bounds-checked, alignment-aware byte/half/word reader over a 32-bit packet BRAM.
// Reads that straddle a word boundary take a second BRAM access.
module packet_rd_align
  import bpf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  packet_rd_align_if.slave bus
);

  state_e               state_r;
  logic [1:0]           off_r;
  logic [1:0]           sz_r;
  logic [WORD_AW-1:0]   waddr_r;
  logic                 span_r;
  logic [31:0]          word0_r;
  logic [31:0]          rd_data_r;
  logic                 data_valid_r;
  logic                 oob_err_r;

  logic [2:0]           nbytes_s;
  logic [12:0]          end_s;
  logic                 reject_s;
  logic                 accept_s;
  logic                 span_s;
  logic [63:0]          pair_s;
  logic [31:0]          align_s;
  logic                 mem_rd_en_s;
  logic [WORD_AW-1:0]   mem_addr_s;

  // Request qualification; 13-bit end address so 4095+4 cannot wrap.
  always_comb begin
    nbytes_s = size_bytes(bus.transfer_sz);
    end_s    = {1'b0, bus.addr} + {10'b0, nbytes_s};
    reject_s = (bus.transfer_sz == SZ_INV) || (end_s > bus.packet_len);
    accept_s = bus.rd_en && !reject_s;
    span_s   = ({1'b0, bus.addr[1:0]} + nbytes_s) > 3'd4;
  end

  // Word pair for the aligner; the second word only exists in SECOND.
  always_comb begin
    if (state_r == ST_SECOND) begin
      pair_s = {word0_r, bus.mem_rdata};
    end else begin
      pair_s = {bus.mem_rdata, 32'h0000_0000};
    end
  end

  pkt_byte_align u_align (
    .pair (pair_s),
    .off  (off_r),
    .sz   (sz_r),
    .data (align_s)
  );

  // BRAM strobe is issued in the same cycle as the decision that needs it.
  always_comb begin
    mem_rd_en_s = 1'b0;
    mem_addr_s  = {WORD_AW{1'b0}};
    if (!rst) begin
      mem_rd_en_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mem_rd_en_s = 1'b1;
            mem_addr_s  = bus.addr[PKT_AW-1:2];
          end else begin
            mem_rd_en_s = 1'b0;
          end
        end
        ST_FIRST: begin
          if (span_r) begin
            mem_rd_en_s = 1'b1;
            mem_addr_s  = waddr_r + 10'd1;
          end else begin
            mem_rd_en_s = 1'b0;
          end
        end
        default: mem_rd_en_s = 1'b0;
      endcase
    end
  end

  // Read FSM with registered result and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      off_r        <= 2'b00;
      sz_r         <= 2'b00;
      waddr_r      <= {WORD_AW{1'b0}};
      span_r       <= 1'b0;
      word0_r      <= 32'h0000_0000;
      rd_data_r    <= 32'h0000_0000;
      data_valid_r <= 1'b0;
      oob_err_r    <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      oob_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.rd_en && reject_s) begin
            oob_err_r <= 1'b1;
            rd_data_r <= 32'h0000_0000;
          end else if (accept_s) begin
            off_r   <= bus.addr[1:0];
            sz_r    <= bus.transfer_sz;
            waddr_r <= bus.addr[PKT_AW-1:2];
            span_r  <= span_s;
            state_r <= ST_FIRST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FIRST: begin
          if (span_r) begin
            word0_r <= bus.mem_rdata;
            state_r <= ST_SECOND;
          end else begin
            rd_data_r    <= align_s;
            data_valid_r <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        ST_SECOND: begin
          rd_data_r    <= align_s;
          data_valid_r <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en  = mem_rd_en_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.rd_data    = rd_data_r;
  assign bus.data_valid = data_valid_r;
  assign bus.oob_err    = oob_err_r;
  assign bus.busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_packet_rd_align.sv
// Directed bench for packet_rd_align: BRAM model plus scoreboards for
// expected results (with latency) and expected BRAM word reads.
module tb_packet_rd_align;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passed;

  packet_rd_align_if bus ();

  packet_rd_align dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  maddr_q[$];
  logic [31:0] mem [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Output and BRAM-read monitors, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.data_valid && bus.oob_err) check("dv_and_oob", 32'd1, 32'd0);
      if (bus.data_valid || bus.oob_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("oob_flag", {31'd0, bus.oob_err}, {31'd0, e.err});
          check("rd_data", bus.rd_data, e.data);
          check("latency", cyc - e.issue, e.lat);
        end
      end
      if (bus.mem_rd_en) begin
        if (maddr_q.size() == 0) begin
          check("unexpected_mem_read", 32'd1, 32'd0);
        end else begin
          check("mem_addr", {22'd0, bus.mem_addr}, {22'd0, maddr_q.pop_front()});
        end
      end
    end
  end

  task automatic issue(input logic [11:0] a, input logic [1:0] sz, input logic [12:0] plen,
                       input logic err, input logic [31:0] data, input int lat, input int nrd);
    exp_t e;
    @(posedge clk);
    #1;
    bus.rd_en       = 1'b1;
    bus.addr        = a;
    bus.transfer_sz = sz;
    bus.packet_len  = plen;
    e.err = err; e.data = data; e.issue = cyc; e.lat = lat;
    exp_q.push_back(e);
    if (nrd >= 1) maddr_q.push_back(a[11:2]);
    if (nrd == 2) maddr_q.push_back(a[11:2] + 10'd1);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || maddr_q.size() != 0); i++) @(posedge clk);
    check("drain_results", exp_q.size(), 32'd0);
    check("drain_reads", maddr_q.size(), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    passed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA0A0_0000 ^ i;
    mem[0]    = 32'h1122_3344;
    mem[1]    = 32'h5566_7788;
    mem[15]   = 32'hDEAD_BEEF;
    mem[1023] = 32'hCAFE_F00D;
    rst             = 1'b0;
    bus.rd_en       = 1'b0;
    bus.addr        = 12'd0;
    bus.transfer_sz = 2'b00;
    bus.packet_len  = 13'd64;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("rst_oob", {31'd0, bus.oob_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mem_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    rst = 1'b1;

    issue(12'd0, 2'b00, 13'd64, 1'b0, 32'h1122_3344, 2, 1);
    wait_done();
    issue(12'd3, 2'b00, 13'd64, 1'b0, 32'h4455_6677, 3, 2);
    wait_done();
    issue(12'd5, 2'b01, 13'd64, 1'b0, 32'h0000_6677, 2, 1);
    wait_done();
    issue(12'd3, 2'b01, 13'd64, 1'b0, 32'h0000_4455, 3, 2);
    wait_done();
    issue(12'd7, 2'b10, 13'd64, 1'b0, 32'h0000_0088, 2, 1);
    wait_done();
    issue(12'd2, 2'b01, 13'd64, 1'b0, 32'h0000_3344, 2, 1);
    wait_done();
    issue(12'd60, 2'b00, 13'd64, 1'b0, 32'hDEAD_BEEF, 2, 1);
    wait_done();
    issue(12'd63, 2'b10, 13'd64, 1'b0, 32'h0000_00EF, 2, 1);
    wait_done();
    issue(12'd61, 2'b00, 13'd64, 1'b1, 32'h0000_0000, 1, 0);
    wait_done();
    issue(12'd4092, 2'b00, 13'd4096, 1'b0, 32'hCAFE_F00D, 2, 1);
    wait_done();
    issue(12'd4, 2'b00, 13'd6, 1'b1, 32'h0000_0000, 1, 0);
    wait_done();
    issue(12'd7, 2'b10, 13'd64, 1'b0, 32'h0000_0088, 2, 1);
    wait_done();
    issue(12'd0, 2'b11, 13'd64, 1'b1, 32'h0000_0000, 1, 0);
    wait_done();

    // Extra rd_en during FIRST of a spanning read must be dropped.
    issue(12'd3, 2'b00, 13'd64, 1'b0, 32'h4455_6677, 3, 2);
    bus.rd_en = 1'b1;
    bus.addr  = 12'd0;
    bus.transfer_sz = 2'b00;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    wait_done();

    // Reset in SECOND: outputs clear at once and the pending result is lost.
    issue(12'd3, 2'b00, 13'd64, 1'b0, 32'h4455_6677, 3, 2);
    @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rd_data", bus.rd_data, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_dv", {31'd0, bus.data_valid}, 32'd0);
    check("mid_rst_mem_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("post_rst_rd_data", bus.rd_data, 32'd0);

    // Back-to-back: second request lands in the first one's data_valid cycle.
    issue(12'd0, 2'b00, 13'd64, 1'b0, 32'h1122_3344, 2, 1);
    issue(12'd4, 2'b00, 13'd64, 1'b0, 32'h5566_7788, 2, 1);
    wait_done();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
